// File: rtl/ssd_pkg.sv
//==============================================================================
// Module   : ssd_pkg
// Brief    : Shared constants for the seven-segment scan decoder.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package ssd_pkg;

  // Active-low segment patterns, bit0 = a .. bit6 = g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SEG  = 2'b01;
  localparam logic [1:0] ERR_AN   = 2'b10;

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_HELD = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ssd_pattern_decode.sv
//==============================================================================
// Module   : ssd_pattern_decode
// Brief    : Maps an active-low segment pattern to {legal, blank, nibble}.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ssd_pattern_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b1;
    blank  = 1'b0;
    nibble = 4'h0;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ssd_scan_decoder.sv
//==============================================================================
// Module   : ssd_scan_decoder
// Brief    : Glitch-filtered reader of a multiplexed seven-segment bus.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ssd_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_valid,
  output logic                    err,
  output logic [1:0]              err_code
);

  import ssd_pkg::*;

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [6:0]                r_seg_q;
  logic [NUM_DIGITS-1:0]     r_an_q;
  logic [4*NUM_DIGITS-1:0]   r_digits;
  logic [NUM_DIGITS-1:0]     r_valid;
  logic [NUM_DIGITS-1:0]     r_seen;
  logic                      r_frame_valid;
  logic                      r_err;
  logic [1:0]                r_err_code;

  logic                      w_legal;
  logic                      w_blank;
  logic [3:0]                w_nibble;
  logic                      w_change;
  logic                      w_accept;
  logic [NUM_DIGITS-1:0]     w_act;
  logic                      w_none;
  logic                      w_multi;
  logic                      w_slot;
  logic                      w_err_an;
  logic                      w_err_seg;
  logic [NUM_DIGITS-1:0]     w_upd;
  logic                      w_seen_full;

  ssd_pattern_decode u_decode (
    .seg    (r_seg_q),
    .legal  (w_legal),
    .blank  (w_blank),
    .nibble (w_nibble)
  );

  assign w_change    = (seg != r_seg_q) || (an != r_an_q);
  assign w_accept    = (r_state == ST_WAIT) && (r_cnt == C_CNT_MAX);
  // x & (x-1) is non-zero exactly when more than one anode is low
  assign w_act       = ~r_an_q;
  assign w_none      = ~|w_act;
  assign w_multi     = |(w_act & (w_act - NUM_DIGITS'(1)));
  assign w_slot      = w_accept && !w_none && !w_multi;
  assign w_err_an    = w_accept && w_multi;
  assign w_err_seg   = w_slot && !w_legal && !w_blank;
  assign w_upd       = {NUM_DIGITS{w_slot && (w_legal || w_blank)}} & w_act;
  assign w_seen_full = &r_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_WAIT;
      r_cnt         <= '0;
      r_seg_q       <= SEG_BLANK;
      r_an_q        <= '1;
      r_digits      <= '0;
      r_valid       <= '0;
      r_seen        <= '0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= ERR_NONE;
    end else begin
      r_seg_q <= seg;
      r_an_q  <= an;

      if (w_change)
        r_cnt <= '0;
      else if (r_cnt != C_CNT_MAX)
        r_cnt <= r_cnt + CNT_W'(1);

      // A pair that changes on its acceptance edge must start a fresh WAIT
      case (r_state)
        ST_WAIT: if (w_accept && !w_change) r_state <= ST_HELD;
        ST_HELD: if (w_change)              r_state <= ST_WAIT;
      endcase

      r_frame_valid <= w_seen_full;
      r_seen        <= (w_seen_full ? '0 : r_seen) | w_upd;

      r_err <= w_err_an || w_err_seg;
      if (w_err_an)
        r_err_code <= ERR_AN;
      else if (w_err_seg)
        r_err_code <= ERR_SEG;

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_upd[i]) begin
          r_digits[4*i +: 4] <= w_blank ? 4'h0 : w_nibble;
          r_valid[i]         <= !w_blank;
        end
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign frame_valid = r_frame_valid;
  assign err         = r_err;
  assign err_code    = r_err_code;

endmodule

`default_nettype wire

// File: doc/ssd_scan_decoder.md
Name: ssd_scan_decoder

Overview:
Reader side of our multiplexed seven-segment display interface. It samples the segment bus and active-low digit-enable lines driven by the display encoder/scanner and filters out scan glitches. It decodes each stable digit pattern back to its hex nibble and assembles complete frames. Used for loop-back self-test of the display path and for capturing display contents from external boards.

Parameters:
NUM_DIGITS, 4, number of scanned digits (anode lines); 1..8
STABLE_CYCLES, 4, consecutive identical samples required to accept a (seg, an) pair; 2..255
CNT_W, 8, stability counter width; must hold STABLE_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
seg  input  7  segment lines, active-low, bit0=a .. bit6=g
an  input  NUM_DIGITS  digit enables, active-low, one-hot-low when a digit is driven
digits  output  4*NUM_DIGITS  decoded nibbles, digit i at [4i+3:4i]
digit_valid  output  NUM_DIGITS  bit i = digit i holds a decoded value (not blank)
frame_valid  output  1  one-cycle pulse when every digit has been accepted since last pulse
err  output  1  one-cycle pulse on an accepted illegal pair
err_code  output  2  01 illegal segment pattern, 10 multiple anodes low, 00 none; held until next err

Behaviour:
- Decodes clk and rst as fixed: one clock; rst asynchronous, active-high.
- Legal patterns (seg, active-low) map to nibbles: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110. Blank=1111111. All other 111 codes are illegal.
- Input stage: seg/an registered every cycle into seg_q/an_q. Stability counter cnt clears to 0 when the newly sampled pair differs from seg_q/an_q. Otherwise it increments, saturating at STABLE_CYCLES-1.
- FSM, two states:
  - WAIT: when cnt == STABLE_CYCLES-1, accept the pair and go to HELD.
  - HELD: stay while the pair is unchanged; any change returns to WAIT with cnt=0.
  - Exactly one acceptance per stable period.
- Latency: a pair first presented before edge E0 and held updates outputs on edge E0+STABLE_CYCLES. A pair held fewer than STABLE_CYCLES edges is never accepted (glitch rejection).
- On acceptance:
  - an all ones: no digit active; nothing updated, no error.
  - an with more than one zero: err=1, err_code=10; digits, valid and seen mask untouched.
  - an one-hot-low at index i, seg legal: digits[i]=nibble, digit_valid[i]=1, seen[i]=1.
  - seg blank: digits[i]=0, digit_valid[i]=0, seen[i]=1.
  - seg illegal: err=1, err_code=01; digit i untouched, seen[i] not set.
- Frame: when seen becomes all ones (registered on an acceptance edge), frame_valid pulses on the following cycle and seen clears. A digit accepted twice before the frame completes simply overwrites.
- Simultaneous events: a frame_valid pulse and an acceptance in the same cycle are both processed; the new acceptance sets seen after the clear.
- Reset mid-operation: asynchronous rst forces the following immediately; on release the first acceptance takes ≥ STABLE_CYCLES edges.
  - WAIT state, cnt=0
  - seg_q=1111111, an_q all ones
  - digits=0, digit_valid=0, seen=0
  - frame_valid=0, err=0, err_code=00

Decomposition:
- Shared package ssd_pkg: SEG_0..SEG_F and SEG_BLANK localparams (7-bit active-low), ERR_NONE/ERR_SEG/ERR_AN codes, FSM state encoding.
- One natural sub-module: ssd_pattern_decode, combinational seg -> {legal, blank, nibble[3:0]}, built from ssd_pkg constants.
- The one-hot-low index/multi-hot detect stays inline.

Test Plan:
- Reset, then hold an=1110, seg=0100100 for 4 edges -> digits[3:0]=2, digit_valid=0001 on 4th edge; no err; holding 20 more cycles produces no further update.
- an=1101, seg=0000011 held 3 edges then seg=0000010 held 4 -> digit1 becomes 6, never B; one acceptance only.
- Scan 1110/1101/1011/0111 with patterns for 1,A,C,F, 4 cycles each -> digits=16'hFCA1, digit_valid=1111, frame_valid single pulse one cycle after last acceptance, seen cleared.
- an=1100, seg=1000000 held 4 -> err pulse, err_code=10, digits unchanged; then an=1110, seg=1111110 held 4 -> err pulse, err_code=01.
- Digit 2 legal then seg=1111111 on an=1011 -> digit_valid[2]=0, digits[11:8]=0, counts toward frame.
- Assert rst mid-scan (cnt=2) -> all outputs zero immediately; after release the same pair needs a full 4 edges to be accepted.
